// File: rtl/expand_pair_issue_if.sv
// Handshake and result bundle between the expand paths, the pairing FIFOs and the float adder.
interface expand_pair_issue_if #(
  parameter int DATA_W = 48,
  parameter int DEPTH  = 8
);
  localparam int FW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] exp1_data_i;
  logic              exp1_valid_i;
  logic              exp1_ready_o;
  logic [DATA_W-1:0] exp2_data_i;
  logic              exp2_valid_i;
  logic              exp2_ready_o;
  logic              stall_i;
  logic              flush_i;
  logic [DATA_W-1:0] expand_1_o;
  logic [DATA_W-1:0] expand_2_o;
  logic              add_en_o;
  logic              sum_valid_o;
  logic [FW-1:0]     fill1_o;
  logic [FW-1:0]     fill2_o;
  logic [15:0]       pair_cnt_o;

  modport slave (
    input  exp1_data_i, exp1_valid_i, exp2_data_i, exp2_valid_i, stall_i, flush_i,
    output exp1_ready_o, exp2_ready_o, expand_1_o, expand_2_o, add_en_o, sum_valid_o,
           fill1_o, fill2_o, pair_cnt_o
  );

  modport master (
    output exp1_data_i, exp1_valid_i, exp2_data_i, exp2_valid_i, stall_i, flush_i,
    input  exp1_ready_o, exp2_ready_o, expand_1_o, expand_2_o, add_en_o, sum_valid_o,
           fill1_o, fill2_o, pair_cnt_o
  );
endinterface

// File: rtl/expand_pair_issue.sv
// Buffers the two expand result streams, issues in-order operand pairs to the float adder and
// flags when each adder sum becomes valid.
module expand_pair_issue #(
  parameter int DATA_W  = 48,
  parameter int DEPTH   = 8,
  parameter int ADD_LAT = 2
) (
  input logic               clk_i,
  input logic               rst_i,
  expand_pair_issue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  logic [DATA_W-1:0] mem1 [DEPTH];
  logic [DATA_W-1:0] mem2 [DEPTH];
  logic [AW-1:0]     wr1, rd1, wr2, rd2;
  logic [FW-1:0]     fill1, fill2;
  logic              push1, push2, issue;

  logic [DATA_W-1:0] expand_1_p0, expand_2_p0;
  logic              vld_p0;
  logic [15:0]       pair_cnt;
  logic [ADD_LAT-1:0] sum_vld_p;

  // Ready drops during reset and flush so no word is lost into a FIFO being cleared.
  assign bus.exp1_ready_o = (fill1 != FULL) && !bus.flush_i && !rst_i;
  assign bus.exp2_ready_o = (fill2 != FULL) && !bus.flush_i && !rst_i;
  assign push1 = bus.exp1_valid_i && bus.exp1_ready_o;
  assign push2 = bus.exp2_valid_i && bus.exp2_ready_o;
  assign issue = (fill1 != '0) && (fill2 != '0) && !bus.stall_i && !bus.flush_i;

  always_ff @(posedge clk_i) begin
    if (push1) mem1[wr1] <= bus.exp1_data_i;
    if (push2) mem2[wr2] <= bus.exp2_data_i;
  end

  // Stage p0: FIFO heads captured into the adder operand registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr1         <= '0;
      rd1         <= '0;
      wr2         <= '0;
      rd2         <= '0;
      fill1       <= '0;
      fill2       <= '0;
      vld_p0      <= 1'b0;
      expand_1_p0 <= '0;
      expand_2_p0 <= '0;
      pair_cnt    <= '0;
    end else if (bus.flush_i) begin
      wr1    <= '0;
      rd1    <= '0;
      wr2    <= '0;
      rd2    <= '0;
      fill1  <= '0;
      fill2  <= '0;
      vld_p0 <= 1'b0;
    end else begin
      if (push1) wr1 <= wr1 + AW'(1);
      if (push2) wr2 <= wr2 + AW'(1);
      fill1  <= fill1 + FW'(push1) - FW'(issue);
      fill2  <= fill2 + FW'(push2) - FW'(issue);
      vld_p0 <= issue;
      if (issue) begin
        rd1         <= rd1 + AW'(1);
        rd2         <= rd2 + AW'(1);
        expand_1_p0 <= mem1[rd1];
        expand_2_p0 <= mem2[rd2];
        pair_cnt    <= pair_cnt + 16'd1;
      end
    end
  end

  // Adder latency tracker; flush leaves in-flight sums alone, only reset discards them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_vld_p <= '0;
    end else begin
      sum_vld_p[0] <= vld_p0;
      for (int i = 1; i < ADD_LAT; i++) sum_vld_p[i] <= sum_vld_p[i-1];
    end
  end

  assign bus.expand_1_o  = expand_1_p0;
  assign bus.expand_2_o  = expand_2_p0;
  assign bus.add_en_o    = vld_p0;
  assign bus.sum_valid_o = sum_vld_p[ADD_LAT-1];
  assign bus.fill1_o     = fill1;
  assign bus.fill2_o     = fill2;
  assign bus.pair_cnt_o  = pair_cnt;
endmodule

// File: tb/tb_expand_pair_issue.sv
// Bench for expand_pair_issue: fixed pairing table, directed corner sequences and random traffic
// checked every cycle against a queue-based reference model.
module tb_expand_pair_issue;
  localparam int DATA_W  = 48;
  localparam int DEPTH   = 8;
  localparam int ADD_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  expand_pair_issue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  expand_pair_issue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADD_LAT(ADD_LAT)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: plain queues of accepted words plus a list of edges at which sums are due.
  logic [DATA_W-1:0] q1[$];
  logic [DATA_W-1:0] q2[$];
  logic [DATA_W-1:0] m_e1 = '0, m_e2 = '0;
  logic              m_add = 1'b0, m_sv = 1'b0;
  logic [15:0]       m_cnt = '0;
  int                edge_no = 0;
  int                due[$];
  int                issued = 0;
  logic              acc1 = 1'b0, acc2 = 1'b0;

  typedef struct {
    logic              v1;
    logic [DATA_W-1:0] d1;
    logic              v2;
    logic [DATA_W-1:0] d2;
    logic              add;
    logic [DATA_W-1:0] e1;
    logic [DATA_W-1:0] e2;
    logic              sv;
    logic [3:0]        f1;
    logic [3:0]        f2;
    logic [15:0]       cnt;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q2.delete();
    due.delete();
    m_e1   = '0;
    m_e2   = '0;
    m_add  = 1'b0;
    m_sv   = 1'b0;
    m_cnt  = '0;
    issued = 0;
    acc1   = 1'b0;
    acc2   = 1'b0;
  endtask

  task automatic model_edge();
    logic iss;
    iss  = (q1.size() != 0) && (q2.size() != 0) && !bus.stall_i && !bus.flush_i;
    acc1 = bus.exp1_valid_i && (q1.size() < DEPTH) && !bus.flush_i;
    acc2 = bus.exp2_valid_i && (q2.size() < DEPTH) && !bus.flush_i;
    edge_no++;
    if (bus.flush_i) begin
      q1.delete();
      q2.delete();
    end else begin
      if (iss) begin
        m_e1 = q1.pop_front();
        m_e2 = q2.pop_front();
        m_cnt++;
        issued++;
        due.push_back(edge_no + ADD_LAT);
      end
      if (acc1) q1.push_back(bus.exp1_data_i);
      if (acc2) q2.push_back(bus.exp2_data_i);
    end
    m_add = iss;
    m_sv  = 1'b0;
    for (int i = due.size() - 1; i >= 0; i--) begin
      if (due[i] == edge_no) begin
        m_sv = 1'b1;
        due.delete(i);
      end
    end
  endtask

  // One clock: ready checked before the edge, everything else after it on the falling edge.
  task automatic step();
    #1;
    chk("exp1_ready", 64'(bus.exp1_ready_o), 64'((q1.size() < DEPTH) && !bus.flush_i));
    chk("exp2_ready", 64'(bus.exp2_ready_o), 64'((q2.size() < DEPTH) && !bus.flush_i));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("add_en",    64'(bus.add_en_o),    64'(m_add));
    chk("expand_1",  64'(bus.expand_1_o),  64'(m_e1));
    chk("expand_2",  64'(bus.expand_2_o),  64'(m_e2));
    chk("sum_valid", 64'(bus.sum_valid_o), 64'(m_sv));
    chk("fill1",     64'(bus.fill1_o),     64'(q1.size()));
    chk("fill2",     64'(bus.fill2_o),     64'(q2.size()));
    chk("pair_cnt",  64'(bus.pair_cnt_o),  64'(m_cnt));
  endtask

  task automatic idle_inputs();
    bus.exp1_valid_i = 1'b0;
    bus.exp2_valid_i = 1'b0;
    bus.stall_i      = 1'b0;
    bus.flush_i      = 1'b0;
  endtask

  // Reset raised in the middle of the low phase; outputs must clear before any clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_add_en",   64'(bus.add_en_o),     64'd0);
    chk("rst_expand_1", 64'(bus.expand_1_o),   64'd0);
    chk("rst_expand_2", 64'(bus.expand_2_o),   64'd0);
    chk("rst_sum_valid",64'(bus.sum_valid_o),  64'd0);
    chk("rst_fill1",    64'(bus.fill1_o),      64'd0);
    chk("rst_fill2",    64'(bus.fill2_o),      64'd0);
    chk("rst_pair_cnt", 64'(bus.pair_cnt_o),   64'd0);
    chk("rst_ready1",   64'(bus.exp1_ready_o), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready1", 64'(bus.exp1_ready_o), 64'd1);
    chk("post_rst_ready2", 64'(bus.exp2_ready_o), 64'd1);
  endtask

  function automatic vec_t mk(input logic v1, input logic [DATA_W-1:0] d1, input logic v2,
                              input logic [DATA_W-1:0] d2, input logic add,
                              input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2,
                              input logic sv, input logic [3:0] f1, input logic [3:0] f2,
                              input logic [15:0] cnt);
    vec_t v;
    v.v1 = v1; v.d1 = d1; v.v2 = v2; v.d2 = d2; v.add = add; v.e1 = e1; v.e2 = e2;
    v.sv = sv; v.f1 = f1; v.f2 = f2; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  initial begin
    logic [DATA_W-1:0] wa, wb;
    logic [DATA_W-1:0] p1[$];
    logic [DATA_W-1:0] p2[$];
    int                idx[$];

    wa = 48'h001_002_003_004;
    wb = 48'h005_006_007_008;
    tbl[0] = mk(1'b1, wa, 1'b0, '0, 1'b0, '0, '0, 1'b0, 4'd1, 4'd0, 16'd0);
    tbl[1] = mk(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 4'd1, 4'd0, 16'd0);
    tbl[2] = mk(1'b0, '0, 1'b1, wb, 1'b0, '0, '0, 1'b0, 4'd1, 4'd1, 16'd0);
    tbl[3] = mk(1'b0, '0, 1'b0, '0, 1'b1, wa, wb, 1'b0, 4'd0, 4'd0, 16'd1);
    tbl[4] = mk(1'b0, '0, 1'b0, '0, 1'b0, wa, wb, 1'b0, 4'd0, 4'd0, 16'd1);
    tbl[5] = mk(1'b0, '0, 1'b0, '0, 1'b0, wa, wb, 1'b1, 4'd0, 4'd0, 16'd1);
    tbl[6] = mk(1'b0, '0, 1'b0, '0, 1'b0, wa, wb, 1'b0, 4'd0, 4'd0, 16'd1);

    bus.exp1_data_i = '0;
    bus.exp2_data_i = '0;
    idle_inputs();
    @(negedge clk);
    do_reset();

    // Pairing of two words arriving at different edges.
    for (int i = 0; i < 7; i++) begin
      bus.exp1_valid_i = tbl[i].v1;
      bus.exp1_data_i  = tbl[i].d1;
      bus.exp2_valid_i = tbl[i].v2;
      bus.exp2_data_i  = tbl[i].d2;
      step();
      chk("t2_add_en",    64'(bus.add_en_o),    64'(tbl[i].add));
      chk("t2_expand_1",  64'(bus.expand_1_o),  64'(tbl[i].e1));
      chk("t2_expand_2",  64'(bus.expand_2_o),  64'(tbl[i].e2));
      chk("t2_sum_valid", 64'(bus.sum_valid_o), 64'(tbl[i].sv));
      chk("t2_fill1",     64'(bus.fill1_o),     64'(tbl[i].f1));
      chk("t2_fill2",     64'(bus.fill2_o),     64'(tbl[i].f2));
      chk("t2_pair_cnt",  64'(bus.pair_cnt_o),  64'(tbl[i].cnt));
    end
    idle_inputs();

    // Fill FIFO-1, refuse a ninth word, then drain against a stream of expand-2 words.
    for (int i = 0; i < 8; i++) begin
      bus.exp1_valid_i = 1'b1;
      bus.exp1_data_i  = 48'(i);
      step();
    end
    chk("t3_fill1_full", 64'(bus.fill1_o), 64'd8);
    bus.exp1_data_i = 48'd99;
    step();
    step();
    chk("t3_fill1_after_9th", 64'(bus.fill1_o), 64'd8);
    chk("t3_ready1_full",     64'(bus.exp1_ready_o), 64'd0);
    bus.exp1_valid_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.exp2_valid_i = (i < 8);
      bus.exp2_data_i  = 48'(100 + i);
      step();
      if (bus.add_en_o) begin
        p1.push_back(bus.expand_1_o);
        p2.push_back(bus.expand_2_o);
        idx.push_back(i);
      end
    end
    bus.exp2_valid_i = 1'b0;
    chk("t3_pulse_count", 64'(p1.size()), 64'd8);
    for (int k = 0; k < p1.size() && k < 8; k++) begin
      chk("t3_pair_e1", 64'(p1[k]), 64'(k));
      chk("t3_pair_e2", 64'(p2[k]), 64'(100 + k));
    end
    if (idx.size() == 8) chk("t3_back_to_back", 64'(idx[7] - idx[0]), 64'd7);

    // Stall holds two ready pairs and the previous operands.
    bus.stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.exp1_valid_i = (i < 2);
      bus.exp2_valid_i = (i < 2);
      bus.exp1_data_i  = 48'(200 + i);
      bus.exp2_data_i  = 48'(300 + i);
      step();
      chk("t4_stall_add_en", 64'(bus.add_en_o), 64'd0);
    end
    chk("t4_hold_e1", 64'(bus.expand_1_o), 64'd7);
    chk("t4_hold_e2", 64'(bus.expand_2_o), 64'd107);
    chk("t4_fill1",   64'(bus.fill1_o),    64'd2);
    idle_inputs();
    step();
    chk("t4_issue1_add", 64'(bus.add_en_o),   64'd1);
    chk("t4_issue1_e1",  64'(bus.expand_1_o), 64'd200);
    step();
    chk("t4_issue2_add", 64'(bus.add_en_o),   64'd1);
    chk("t4_issue2_e2",  64'(bus.expand_2_o), 64'd301);
    step();
    chk("t4_done_add",   64'(bus.add_en_o),   64'd0);

    // Flush with fill1 = 3, fill2 = 0 and one sum in flight.
    bus.exp1_valid_i = 1'b1; bus.exp1_data_i = 48'd400; step();
    bus.exp1_data_i = 48'd401; step();
    bus.exp2_valid_i = 1'b1; bus.exp1_data_i = 48'd402; bus.exp2_data_i = 48'd500; step();
    bus.exp2_valid_i = 1'b0; bus.exp1_data_i = 48'd403; step();
    chk("t5_inflight_add", 64'(bus.add_en_o), 64'd1);
    chk("t5_pre_fill1",    64'(bus.fill1_o),  64'd3);
    chk("t5_pre_fill2",    64'(bus.fill2_o),  64'd0);
    bus.flush_i = 1'b1; bus.exp1_data_i = 48'd404;
    #1 chk("t5_flush_ready1", 64'(bus.exp1_ready_o), 64'd0);
    step();
    chk("t5_flush_fill1", 64'(bus.fill1_o),  64'd0);
    chk("t5_flush_add",   64'(bus.add_en_o), 64'd0);
    idle_inputs();
    step();
    chk("t5_inflight_sum", 64'(bus.sum_valid_o), 64'd1);
    chk("t5_fill1_stays",  64'(bus.fill1_o),     64'd0);
    step();

    // Random producers with holding, random stall and occasional flush.
    acc1 = 1'b0;
    acc2 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!bus.exp1_valid_i || acc1) begin
        bus.exp1_valid_i = ($urandom_range(0, 99) < 60);
        bus.exp1_data_i  = rnd_word();
      end
      if (!bus.exp2_valid_i || acc2) begin
        bus.exp2_valid_i = ($urandom_range(0, 99) < 60);
        bus.exp2_data_i  = rnd_word();
      end
      bus.stall_i = ($urandom_range(0, 99) < 25);
      bus.flush_i = ($urandom_range(0, 99) < 2);
      step();
    end
    idle_inputs();

    // Reset while a sum is pending: the pulse must never appear.
    bus.exp1_valid_i = 1'b1; bus.exp2_valid_i = 1'b1;
    bus.exp1_data_i = 48'd600; bus.exp2_data_i = 48'd700;
    step();
    bus.exp1_valid_i = 1'b0; bus.exp2_valid_i = 1'b0;
    step();
    chk("midrst_add_before", 64'(bus.add_en_o), 64'd1);
    do_reset();
    for (int i = 0; i < 4; i++) step();

    // Counter wrap over 65537 issued pairs.
    bus.exp1_valid_i = 1'b1;
    bus.exp2_valid_i = 1'b1;
    for (int c = 0; c < 70000 && issued < 65537; c++) begin
      bus.exp1_data_i = 48'(c);
      bus.exp2_data_i = 48'(c + 1);
      step();
      if (issued == 65536) chk("wrap_zero", 64'(bus.pair_cnt_o), 64'd0);
    end
    chk("wrap_issued",   64'(issued),          64'd65537);
    chk("wrap_pair_cnt", 64'(bus.pair_cnt_o),  64'd1);
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
